vga2tmds_encoder: RTL and testbench

Downstream consumer of the VGA timing/pixel generator. Takes the 8-bit RGB, hsync, vsync and data-enable outputs and produces three 10-bit DVI/TMDS symbols (blue, green, red) per pixel clock. Encoding uses the standard DVI 1.0 transition-minimised algorithm with per-channel running-disparity DC balance. Its outputs feed the 10:1 serialisers / DDR output stage.

---
 rtl/vga2tmds_encoder_if.sv | 27 ++
 rtl/vga2tmds_encoder.sv | 174 +++++++++++++++++
 tb/tb_vga2tmds_encoder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga2tmds_encoder_if.sv
// Pixel/sync bundle between the VGA timing stage and the TMDS encoder.
//   in_red/in_green/in_blue : 8-bit pixel components
//   in_hsync/in_vsync       : sync levels, carried on blue C0/C1 during blanking
//   in_de                   : 1 = active pixel, 0 = blanking (control token)
//   out_red/green/blue      : 10-bit TMDS symbols (channels 2/1/0)
// master = VGA side (drives pixels), slave = encoder (drives symbols).
interface vga2tmds_encoder_if;
    logic [7:0] in_red;
    logic [7:0] in_green;
    logic [7:0] in_blue;
    logic       in_hsync;
    logic       in_vsync;
    logic       in_de;
    logic [9:0] out_red;
    logic [9:0] out_green;
    logic [9:0] out_blue;

    modport master (
        output in_red, in_green, in_blue, in_hsync, in_vsync, in_de,
        input  out_red, out_green, out_blue
    );

    modport slave (
        input  in_red, in_green, in_blue, in_hsync, in_vsync, in_de,
        output out_red, out_green, out_blue
    );
endinterface

// File: rtl/vga2tmds_encoder.sv
// DVI 1.0 TMDS encoder: three independent 3-stage channel pipelines.
// Ports:
//   clk_pixel      : pixel clock
//   rst_n          : synchronous active-low reset (wins over clk_pixel_ena)
//   clk_pixel_ena  : pipeline advance; every register holds when low
//   bus (slave)    : RGB/hsync/vsync/de in, three 10-bit symbols out
// Lane 0 = blue, lane 1 = green, lane 2 = red.

// One TMDS channel.
//   S1: register data/de/C, count ones of data
//   S2: transition-minimised q_m, ones/zeros of q_m[7:0]
//   S3: DC balance or control token, running disparity
module tmds_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] d,
    input  logic       de,
    input  logic [1:0] c,
    output logic [9:0] sym
);
    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;
    localparam logic signed [5:0] CNT_MAX = 6'sd16;
    localparam logic signed [5:0] CNT_MIN = -6'sd16;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    // S1
    logic [7:0] d1_q, d1_d;
    logic       de1_q, de1_d;
    logic [1:0] c1_q, c1_d;
    logic [3:0] n1d_q, n1d_d;
    // S2
    logic [8:0] qm_q, qm_d;
    logic       de2_q, de2_d;
    logic [1:0] c2_q, c2_d;
    logic [3:0] n1q_q, n1q_d;
    logic [3:0] n0q_q, n0q_d;
    logic       use_xnor;
    // S3
    logic [9:0]        sym_q, sym_d;
    logic signed [5:0] cnt_q, cnt_d;
    logic signed [5:0] n1s, n0s, diff;

    always_comb begin
        d1_d  = d;
        de1_d = de;
        c1_d  = c;
        n1d_d = ones8(d);
    end

    always_comb begin
        use_xnor = (n1d_q > 4'd4) || ((n1d_q == 4'd4) && !d1_q[0]);
        qm_d     = '0;
        qm_d[0]  = d1_q[0];
        for (int i = 1; i < 8; i++)
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ d1_q[i]) : (qm_d[i-1] ^ d1_q[i]);
        qm_d[8]  = ~use_xnor;
        n1q_d    = ones8(qm_d[7:0]);
        n0q_d    = 4'd8 - n1q_d;
        de2_d    = de1_q;
        c2_d     = c1_q;
    end

    // N1/N0 are 0..8, so zero-extending to 6-bit signed is exact.
    assign n1s  = $signed({2'b00, n1q_q});
    assign n0s  = $signed({2'b00, n0q_q});
    assign diff = n1s - n0s;

    always_comb begin
        sym_d = sym_q;
        cnt_d = cnt_q;
        if (!de2_q) begin
            cnt_d = '0;
            case (c2_q)
                2'b00:   sym_d = TOK_00;
                2'b01:   sym_d = TOK_01;
                2'b10:   sym_d = TOK_10;
                default: sym_d = TOK_11;
            endcase
        end else if ((cnt_q == 6'sd0) || (n1q_q == n0q_q)) begin
            sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if (((cnt_q > 6'sd0) && (n1q_q > n0q_q)) ||
                     ((cnt_q < 6'sd0) && (n0q_q > n1q_q))) begin
            // Invert to pull the running disparity back toward zero.
            sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d = cnt_q + (qm_q[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
            sym_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d = cnt_q - (qm_q[8] ? 6'sd0 : 6'sd2) + diff;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d1_q  <= '0;
            de1_q <= 1'b0;
            c1_q  <= '0;
            n1d_q <= '0;
            qm_q  <= '0;
            de2_q <= 1'b0;
            c2_q  <= '0;
            n1q_q <= '0;
            n0q_q <= '0;
            sym_q <= TOK_00;
            cnt_q <= '0;
        end else if (ena) begin
            d1_q  <= d1_d;
            de1_q <= de1_d;
            c1_q  <= c1_d;
            n1d_q <= n1d_d;
            qm_q  <= qm_d;
            de2_q <= de2_d;
            c2_q  <= c2_d;
            n1q_q <= n1q_d;
            n0q_q <= n0q_d;
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign sym = sym_q;

    // The algorithm keeps disparity well inside +/-16; leaving that band means a broken update.
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        (cnt_q >= CNT_MIN) && (cnt_q <= CNT_MAX));
endmodule

module vga2tmds_encoder #(
    parameter bit c_ctrl_on_blue = 1'b1
) (
    input  logic              clk_pixel,
    input  logic              rst_n,
    input  logic              clk_pixel_ena,
    vga2tmds_encoder_if.slave bus
);
    localparam int NUM_LANES = 3;

    logic [NUM_LANES-1:0][7:0] lane_d;
    logic [NUM_LANES-1:0][1:0] lane_c;
    logic [NUM_LANES-1:0][9:0] lane_sym;

    always_comb begin
        lane_d    = {bus.in_red, bus.in_green, bus.in_blue};
        lane_c    = '0;
        // C1C0 = vsync,hsync on blue only; green/red always send C=00.
        lane_c[0] = c_ctrl_on_blue ? {bus.in_vsync, bus.in_hsync} : 2'b00;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        tmds_lane u_lane (
            .clk   (clk_pixel),
            .rst_n (rst_n),
            .ena   (clk_pixel_ena),
            .d     (lane_d[i]),
            .de    (bus.in_de),
            .c     (lane_c[i]),
            .sym   (lane_sym[i])
        );
    end

    assign bus.out_blue  = lane_sym[0];
    assign bus.out_green = lane_sym[1];
    assign bus.out_red   = lane_sym[2];
endmodule

// File: tb/tb_vga2tmds_encoder.sv
// Bench for vga2tmds_encoder: a per-pixel DVI encoder model with a 3-deep
// symbol delay line, compared with the DUT on every falling edge, plus a
// symbol decoder that recovers active pixels, plus literal expectations.
module tb_vga2tmds_encoder;
    localparam bit C_CTRL = 1'b1;

    logic clk_pixel = 1'b0;
    logic rst_n;
    logic clk_pixel_ena;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;

    vga2tmds_encoder_if bus();

    vga2tmds_encoder #(.c_ctrl_on_blue(C_CTRL)) dut (
        .clk_pixel     (clk_pixel),
        .rst_n         (rst_n),
        .clk_pixel_ena (clk_pixel_ena),
        .bus           (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Model: [stage][channel], stage 2 is what the outputs must show. ch 0=blue,1=green,2=red.
    logic [9:0] m_sym [3][3];
    logic [7:0] m_dat [3][3];
    logic       m_de  [3];
    int         m_cnt [3];

    function automatic logic [9:0] enc(input logic [7:0] d, input logic de,
                                       input logic [1:0] c, inout int cnt);
        logic [7:0] q;
        logic       xn;
        int n1, n0, q8;
        if (!de) begin
            cnt = 0;
            case (c)
                2'b00:   return 10'h354;
                2'b01:   return 10'h0AB;
                2'b10:   return 10'h154;
                default: return 10'h2AB;
            endcase
        end
        xn   = ($countones(d) > 4) || ($countones(d) == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q8 = xn ? 0 : 1;
        n1 = $countones(q);
        n0 = 8 - n1;
        if (cnt == 0 || n1 == n0) begin
            cnt = cnt + ((q8 == 1) ? (n1 - n0) : (n0 - n1));
            return (q8 == 1) ? {2'b01, q} : {2'b10, ~q};
        end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
            cnt = cnt + 2 * q8 + (n0 - n1);
            return {1'b1, q8[0], ~q};
        end else begin
            cnt = cnt - 2 * (1 - q8) + (n1 - n0);
            return {1'b0, q8[0], q};
        end
    endfunction

    // Receiver-side decode of a data symbol back to the 8-bit pixel.
    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] q, d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : model
        logic [7:0] px [3];
        logic [1:0] cc [3];
        forever begin
            @(posedge clk_pixel);
            if (!rst_n) begin
                for (int s = 0; s < 3; s++) begin
                    m_de[s] = 1'b0;
                    for (int ch = 0; ch < 3; ch++) begin
                        m_sym[s][ch] = 10'h354;
                        m_dat[s][ch] = 8'h00;
                    end
                end
                for (int ch = 0; ch < 3; ch++) m_cnt[ch] = 0;
            end else if (clk_pixel_ena) begin
                px[0] = bus.in_blue; px[1] = bus.in_green; px[2] = bus.in_red;
                cc[0] = C_CTRL ? {bus.in_vsync, bus.in_hsync} : 2'b00;
                cc[1] = 2'b00;
                cc[2] = 2'b00;
                for (int s = 2; s > 0; s--) begin
                    m_de[s] = m_de[s-1];
                    for (int ch = 0; ch < 3; ch++) begin
                        m_sym[s][ch] = m_sym[s-1][ch];
                        m_dat[s][ch] = m_dat[s-1][ch];
                    end
                end
                m_de[0] = bus.in_de;
                for (int ch = 0; ch < 3; ch++) begin
                    m_sym[0][ch] = enc(px[ch], bus.in_de, cc[ch], m_cnt[ch]);
                    m_dat[0][ch] = px[ch];
                end
            end
        end
    end

    initial begin : compare
        logic [9:0] o [3];
        forever begin
            @(negedge clk_pixel);
            if (chk_en) begin
                o[0] = bus.out_blue; o[1] = bus.out_green; o[2] = bus.out_red;
                chk("model_blue",  {22'd0, o[0]}, {22'd0, m_sym[2][0]});
                chk("model_green", {22'd0, o[1]}, {22'd0, m_sym[2][1]});
                chk("model_red",   {22'd0, o[2]}, {22'd0, m_sym[2][2]});
                if (m_de[2])
                    for (int ch = 0; ch < 3; ch++)
                        chk("decode_pixel", {24'd0, dec(o[ch])}, {24'd0, m_dat[2][ch]});
            end
        end
    end

    task automatic cyc();
        @(posedge clk_pixel);
        @(negedge clk_pixel);
    endtask

    task automatic set_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic hs, input logic vs, input logic de);
        bus.in_red = r; bus.in_green = g; bus.in_blue = b;
        bus.in_hsync = hs; bus.in_vsync = vs; bus.in_de = de;
    endtask

    task automatic rand_px();
        set_px(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) != 0));
    endtask

    task automatic chk_all(input string name, input logic [9:0] b, input logic [9:0] g,
                           input logic [9:0] r);
        chk({name, "_blue"},  {22'd0, bus.out_blue},  {22'd0, b});
        chk({name, "_green"}, {22'd0, bus.out_green}, {22'd0, g});
        chk({name, "_red"},   {22'd0, bus.out_red},   {22'd0, r});
    endtask

    logic [9:0] blank_tok [4];
    logic       hs_v [4];
    logic       vs_v [4];

    initial begin
        chk_en = 1'b1;
        // Reset with random inputs and random ena: reset must win.
        rst_n = 1'b0;
        clk_pixel_ena = 1'($urandom);
        rand_px();
        repeat (4) begin
            cyc();
            chk_all("reset", 10'h354, 10'h354, 10'h354);
            rand_px();
            clk_pixel_ena = 1'($urandom);
        end
        chk("reset_cnt", m_cnt[0] + m_cnt[1] + m_cnt[2], 0);

        rst_n = 1'b1;
        clk_pixel_ena = 1'b1;
        set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc();

        // Two 0x00 pixels from cnt=0.
        set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("cnt_after_00_a", m_cnt[0], -8);
        cyc();
        chk("cnt_after_00_b", m_cnt[0], 2);
        set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("blue_00_first", {22'd0, bus.out_blue}, 32'h100);
        cyc();
        chk("blue_00_second", {22'd0, bus.out_blue}, 32'h3FF);

        // 0xFF from cnt=0, then blanking clears cnt.
        set_px(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("cnt_after_ff", m_cnt[1], -8);
        set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("cnt_after_blank", m_cnt[1], 0);
        cyc();
        chk("green_ff", {22'd0, bus.out_green}, 32'h200);
        cyc();
        chk("green_blank", {22'd0, bus.out_green}, 32'h354);

        // Control tokens for (hsync,vsync) = 00,10,01,11.
        blank_tok = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        hs_v = '{1'b0, 1'b1, 1'b0, 1'b1};
        vs_v = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            set_px(8'($urandom), 8'($urandom), 8'($urandom), hs_v[k], vs_v[k], 1'b0);
            repeat (3) cyc();
            chk_all("ctrl_token", blank_tok[k], 10'h354, 10'h354);
        end

        // Random stream with ena gaps: 1,0,0,1 pattern then random.
        for (int i = 0; i < 600; i++) begin
            rand_px();
            clk_pixel_ena = (i < 200) ? ((i % 4 == 0) || (i % 4 == 3)) : 1'($urandom);
            cyc();
        end

        // 20-line slice of 640x480 timing (800 clocks/line), one-clock reset mid-line.
        // The vsync pulse is placed early so it lands inside the slice.
        clk_pixel_ena = 1'b1;
        for (int ln = 0; ln < 20; ln++) begin
            for (int h = 0; h < 800; h++) begin
                set_px(8'($urandom), 8'($urandom), 8'($urandom),
                       !(h >= 656 && h < 752), !(ln >= 2 && ln < 4), (h < 640) && (ln != 3));
                if (ln == 10 && h == 300) begin
                    rst_n = 1'b0;
                    cyc();
                    chk_all("midline_reset", 10'h354, 10'h354, 10'h354);
                    chk("midline_reset_cnt", m_cnt[0] + m_cnt[1] + m_cnt[2], 0);
                    rst_n = 1'b1;
                end else begin
                    cyc();
                end
            end
        end

        set_px(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        repeat (4) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
